// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, one partial product per clock.
//
// Operands are reduced to magnitudes on entry and the magnitude product is
// negated on exit when the operand signs differ. Control is a start/done
// handshake: start is only looked at in IDLE, done pulses for one cycle when
// the product register has been updated.
//
// Optional feature macro: MULT_SIGNED_EN
//   defined   -> operands are two's complement (entry/exit negation active)
//   undefined -> operands are unsigned, loaded as-is, no exit negation
//
// Ports:
//   i_clock    rising-edge clock
//   i_reset    synchronous active-high reset (aborts any operation)
//   i_start    start request, sampled only in IDLE
//   i_a        multiplicand (WIDTH bits)
//   i_b        multiplier   (WIDTH bits)
//   o_busy     high whenever the FSM is not in IDLE
//   o_done     one-cycle pulse, o_product is valid
//   o_product  2*WIDTH-bit result register, holds until next completion
module mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_sgn;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_load;
  logic                 w_step;
  logic                 w_fix;
  logic                 w_last;

  // Magnitude of an operand. 0x8000 maps to 0x8000, which is correct when the
  // result is read as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
`ifdef MULT_SIGNED_EN
    f_mag = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
`else
    f_mag = x;
`endif
  endfunction

  // Sign of the final product.
  function automatic logic f_sgn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MULT_SIGNED_EN
    f_sgn = x[WIDTH-1] ^ y[WIDTH-1];
`else
    f_sgn = 1'b0;
`endif
  endfunction

  // Last RUN cycle: WIDTH partial products have been considered.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next = ST_FIX;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath enables decoded from the current state.
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      ST_IDLE: w_load = i_start;
      ST_RUN:  w_step = 1'b1;
      ST_FIX:  w_fix  = 1'b1;
      ST_DONE: w_load = 1'b0;
      default: w_load = 1'b0;
    endcase
  end

  // Operand load and shift-add iteration.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sgn    <= 1'b0;
    end else if (w_load) begin
      r_mcand  <= f_mag(i_a);
      r_mplier <= f_mag(i_b);
      r_sgn    <= f_sgn(i_a, i_b);
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      // Add the zero-extended multiplicand at bit offset cnt.
      if (r_mplier[0]) begin
        r_acc <= r_acc + ({{WIDTH{1'b0}}, r_mcand} << r_cnt);
      end
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result register: written only at the FIX edge, so an aborted operation
  // never leaves a partial value here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_product <= '0;
    end else if (w_fix) begin
      r_product <= r_sgn ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    end
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_mult_seq.sv
// Directed testbench for mult_seq (WIDTH=16). Expected values are
// hand-computed; signed/unsigned variants selected by MULT_SIGNED_EN.
module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cyc = 0;

  mult_seq #(.WIDTH(16)) dut (
    .i_clock   (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_a       (a_s),
    .i_b       (b_s),
    .o_busy    (busy),
    .o_done    (done),
    .o_product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept at edge 0, then edges 1..18 with optional
  // start re-pulses (edges p1/p2/p3) carrying different operands.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string tag, input int p1, input int p2, input int p3);
    logic busy_ok;
    logic done_ok;
    int   done_n;
    a_s = a;
    b_s = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_s = 16'($urandom);
    b_s = 16'($urandom);
    check({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
    busy_ok = 1'b1;
    done_ok = 1'b1;
    done_n  = 0;
    for (int k = 1; k <= 18; k++) begin
      if (k == p1 || k == p2 || k == p3) begin
        start = 1'b1;
        a_s = 16'hFFFF;
        b_s = 16'hFFFF;
      end
      tick();
      start = 1'b0;
      if (busy !== (k <= 17)) busy_ok = 1'b0;
      if (done !== (k == 17)) done_ok = 1'b0;
      if (done === 1'b1) done_n++;
      if (k == 17) begin
        done_cyc = cyc;
        check({tag, "_prod"}, {32'd0, product}, {32'd0, exp});
      end
    end
    check({tag, "_busy_seq"}, {63'd0, busy_ok}, 64'd1);
    check({tag, "_done_seq"}, {63'd0, done_ok}, 64'd1);
    check({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    check({tag, "_hold"}, {32'd0, product}, {32'd0, exp});
  endtask

  initial begin
    logic [31:0] exp_neg;
    logic [31:0] exp_max;
    logic        quiet_ok;
    int          d1;
`ifdef MULT_SIGNED_EN
    exp_neg = 32'hFFFF_FFF1;
    exp_max = 32'hFFFF_8001;
`else
    exp_neg = 32'h0004_FFF1;
    exp_max = 32'h7FFE_8001;
`endif
    reset = 1'b1;
    start = 1'b0;
    a_s = 16'd0;
    b_s = 16'd0;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_prod", {32'd0, product}, 64'd0);
    reset = 1'b0;
    tick();

    run_op(16'h0003, 16'h0005, 32'h0000_000F, "m3x5", -1, -1, -1);
    run_op(16'hFFFD, 16'h0005, exp_neg, "neg3x5", -1, -1, -1);
    run_op(16'h8000, 16'h8000, 32'h4000_0000, "min_min", -1, -1, -1);
    run_op(16'h7FFF, 16'hFFFF, exp_max, "max_m1", -1, -1, -1);
    run_op(16'h0000, 16'hFFFF, 32'h0000_0000, "zero", -1, -1, -1);
    run_op(16'h0009, 16'h000B, 32'h0000_0063, "repulse", 5, 17, 18);

    // Reset at edge 9 in the middle of RUN.
    a_s = 16'h1234;
    b_s = 16'h0056;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_prod", {32'd0, product}, 64'd0);
    quiet_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) quiet_ok = 1'b0;
    end
    check("abort_quiet", {63'd0, quiet_ok}, 64'd1);
    run_op(16'h0007, 16'h0006, 32'h0000_002A, "m7x6", -1, -1, -1);

    // Back-to-back: second start sampled 20 edges after the first.
    run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, "b2b_1", -1, -1, -1);
    d1 = done_cyc;
    tick();
    run_op(16'h0100, 16'h0100, 32'h0001_0000, "b2b_2", -1, -1, -1);
    check("b2b_gap", 64'(done_cyc - d1), 64'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
